cnt_seq_checker: RTL

Receiving-side companion to the mod-4 divide counter: samples a 2-bit count stream each clock, locks onto a valid 0→1→2→3→0 sequence, then flags sequence violations, counts them, decodes the current phase to one-hot and emits a wrap pulse. It sits downstream of the divide counter's `po_cnt` output in the same clock domain, as a self-checking monitor for that output and a phase decoder for logic that needs per-phase enables.

---
 rtl/cnt_seq_checker.sv | 122 ++++++++++++
 1 files changed

// File: rtl/cnt_seq_checker.sv
// cnt_seq_checker: receive-side monitor for a mod-4 count stream.
// Locks onto a clean 0->1->2->3->0 sequence, then flags, counts and
// tracks violations. Also decodes the current phase to one-hot and
// emits a wrap pulse.
// Optional feature macro: CNT_CHK_STICKY_EN adds po_err_sticky, a flag
// that is set by any error pulse and cleared only by rst.
module cnt_seq_checker #(
   parameter int LOCK_CNT = 4,
   parameter int MISS_MAX = 2,
   parameter int ERR_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       pi_cnt,
   output logic             po_lock,
   output logic             po_err,
   output logic [ERR_W-1:0] po_err_cnt,
   output logic             po_wrap,
   output logic [3:0]       po_phase
`ifdef CNT_CHK_STICKY_EN
   ,
   output logic             po_err_sticky
`endif
);

   typedef enum logic [1:0] {IDLE, ACQ, LOCKED} state_t;

   localparam logic [3:0]       LOCK_V  = 4'(LOCK_CNT);
   localparam logic [3:0]       MISS_V  = 4'(MISS_MAX);
   localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);

   state_t     state;
   logic [1:0] cnt_q;
   logic       vld_q;
   logic [3:0] run;
   logic [3:0] miss;
   logic       match;

   // Match: the new sample is the previous sample plus one (mod 4).
   // Without a previous sample there is nothing to compare against.
   always_comb begin
      match = vld_q && (pi_cnt == 2'(cnt_q + 2'd1));
   end

   // Lock FSM, counters and all registered outputs.
   // NOTE: every assignment to state is non-blocking. All decisions on
   // this edge then see the values from before the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         cnt_q         <= 2'd0;
         vld_q         <= 1'b0;
         run           <= 4'd0;
         miss          <= 4'd0;
         po_lock       <= 1'b0;
         po_err        <= 1'b0;
         po_err_cnt    <= '0;
         po_wrap       <= 1'b0;
         po_phase      <= 4'b0000;
`ifdef CNT_CHK_STICKY_EN
         po_err_sticky <= 1'b0;
`endif
      end else begin
         // Compare against the last observed sample. A glitch then
         // resynchronises instead of causing errors to keep repeating.
         cnt_q    <= pi_cnt;
         vld_q    <= 1'b1;
         po_phase <= 4'b0001 << pi_cnt;
         po_err   <= 1'b0;
         po_wrap  <= 1'b0;

         case (state)
            IDLE: begin
               state <= ACQ;
            end

            ACQ: begin
               if (match) begin
                  if (run + 4'd1 == LOCK_V) begin
                     state   <= LOCKED;
                     po_lock <= 1'b1;
                     run     <= 4'd0;
                     miss    <= 4'd0;
                  end else begin
                     run <= run + 4'd1;
                  end
               end else begin
                  run <= 4'd0;
               end
            end

            LOCKED: begin
               if (match) begin
                  miss    <= 4'd0;
                  po_wrap <= (cnt_q == 2'd3);
               end else begin
                  po_err <= 1'b1;
`ifdef CNT_CHK_STICKY_EN
                  po_err_sticky <= 1'b1;
`endif
                  if (po_err_cnt != '1) begin
                     po_err_cnt <= po_err_cnt + ERR_ONE;
                  end
                  if (miss + 4'd1 == MISS_V) begin
                     state   <= ACQ;
                     po_lock <= 1'b0;
                     run     <= 4'd0;
                     miss    <= 4'd0;
                  end else begin
                     miss <= miss + 4'd1;
                  end
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
